// File: rtl/fir_pkg.sv
// Shared constants for the FIR output path and the accumulator width helper.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
package fir_pkg;
  localparam int FIR_OUT_W = 10;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_DECIM = 4;
  localparam int DEF_SHIFT = 2;
  localparam int DEF_DEPTH = 8;

  // Width that holds the sum of 'decim' full-scale samples without wrapping.
  function automatic int acc_width(input int in_w, input int decim);
    return in_w + $clog2(decim);
  endfunction
endpackage

// File: rtl/fir_decim_out_if.sv
// Sample-in / result-out bundle between the FIR, the decimator and its consumer.
// Latency: none (wires only).
// Backpressure: dout_ready from the consumer; din side has no ready.
interface fir_decim_out_if import fir_pkg::*; #(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [IN_W-1:0]  din;
  logic             din_valid;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             clr_ovf;

  // Decimator side.
  modport slave (
    input  din, din_valid, dout_ready, clr_ovf,
    output dout, dout_valid, count, ovf
  );

  // FIR + consumer side.
  modport master (
    output din, din_valid, dout_ready, clr_ovf,
    input  dout, dout_valid, count, ovf
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible at o_dat right after the push edge.
// Backpressure: push when full succeeds only with a same-cycle pop, else o_drop.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_dat,
  input  logic                     i_rdy,
  output logic [W-1:0]             o_dat,
  output logic                     o_vld,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [AW:0]  w_count;
  logic         w_full;
  logic         w_pop;
  logic         w_wr;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign w_count = r_wr - r_rd;
  assign w_full  = (w_count == (AW+1)'(DEPTH));
  assign o_vld   = (w_count != '0);
  assign w_pop   = o_vld & i_rdy;
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;
  assign o_count = w_count;
  assign o_dat   = o_vld ? r_mem[r_rd[AW-1:0]] : '0;

  // Storage array needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_dat;
  end

  // Advance write/read pointers on accepted push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/fir_decim_out.sv
// Boxcar decimator: sums DECIM FIR samples, shifts, saturates, queues the result.
// Latency: result visible right after the edge accepting the group's last sample.
// Backpressure: none upstream; a full FIFO without pop drops the result, sets ovf.
module fir_decim_out import fir_pkg::*; #(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DECIM = DEF_DECIM,
  parameter int SHIFT = DEF_SHIFT,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  fir_decim_out_if.slave     bus
);
  localparam int ACC_W = acc_width(IN_W, DECIM);
  localparam int PH_W  = $clog2(DECIM);
  localparam logic [OUT_W-1:0] MAX_OUT = '1;

  logic [PH_W-1:0]  r_ph;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_res;
  logic [OUT_W-1:0] w_sat;
  logic             w_first;
  logic             w_dump;
  logic             w_drop;

  assign w_first = (r_ph == '0);
  assign w_dump  = bus.din_valid & (r_ph == PH_W'(DECIM-1));
  assign w_sum   = r_acc + ACC_W'(bus.din);
  assign w_res   = w_sum >> SHIFT;
  assign w_sat   = (w_res > ACC_W'(MAX_OUT)) ? MAX_OUT : w_res[OUT_W-1:0];

  // Phase and running sum only move on valid samples; phase wraps after the dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ph  <= '0;
      r_acc <= '0;
    end else if (bus.din_valid) begin
      r_ph  <= w_dump ? '0 : r_ph + 1'b1;
      r_acc <= w_first ? ACC_W'(bus.din) : w_sum;
    end
  end

  // Sticky drop flag; a drop on the same edge wins over a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_ovf <= 1'b0;
    else if (w_drop)       r_ovf <= 1'b1;
    else if (bus.clr_ovf)  r_ovf <= 1'b0;
  end

  assign bus.ovf = r_ovf;

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_dump),
    .i_dat   (w_sat),
    .i_rdy   (bus.dout_ready),
    .o_dat   (bus.dout),
    .o_vld   (bus.dout_valid),
    .o_count (bus.count),
    .o_drop  (w_drop)
  );
endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: table vectors plus hand-built corner sequences.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: dout_ready driven per vector.
module tb_fir_decim_out;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  fir_decim_out_if bus();

  fir_decim_out dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int din;
    bit vld;
    bit rdy;
    bit clr;
    int e_dout;
    bit e_vld;
    int e_cnt;
    bit e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int din, bit vld, bit rdy, bit clr,
                              int e_dout, bit e_vld, int e_cnt, bit e_ovf);
    vec_t v;
    v.din = din; v.vld = vld; v.rdy = rdy; v.clr = clr;
    v.e_dout = e_dout; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string nm, input int e_dout, input bit e_vld,
                       input int e_cnt, input bit e_ovf);
    n_vec++;
    if ($isunknown(bus.dout) || int'(bus.dout) != e_dout) begin
      n_err++;
      $display("FAIL %s: dout got %0d want %0d", nm, bus.dout, e_dout);
    end
    if (bus.dout_valid !== e_vld) begin
      n_err++;
      $display("FAIL %s: dout_valid got %b want %b", nm, bus.dout_valid, e_vld);
    end
    if ($isunknown(bus.count) || int'(bus.count) != e_cnt) begin
      n_err++;
      $display("FAIL %s: count got %0d want %0d", nm, bus.count, e_cnt);
    end
    if (bus.ovf !== e_ovf) begin
      n_err++;
      $display("FAIL %s: ovf got %b want %b", nm, bus.ovf, e_ovf);
    end
  endtask

  task automatic step(input int din, input bit vld, input bit rdy, input bit clr);
    bus.din        = 10'(din);
    bus.din_valid  = vld;
    bus.dout_ready = rdy;
    bus.clr_ovf    = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[8];
    int c;
    bus.din = '0; bus.din_valid = 1'b0; bus.dout_ready = 1'b0; bus.clr_ovf = 1'b0;
    #12;
    check("reset", 0, 0, 0, 0);
    rst = 1'b1;

    // Averaging: two groups of 100, each result popped on the following edge.
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(100, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(100, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(100, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(100, 1, 1, 0, 100, 1, 1, 0));
    end
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    // Saturation: 4092>>2 = 1023 clips to 255.
    tbl.push_back(mk(1023, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1023, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1023, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1023, 1, 0, 0, 255, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    // Gaps: 10,20, five idle cycles carrying junk data, 30,40 -> 25.
    tbl.push_back(mk(10, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(20, 1, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(999, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(30, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(40, 1, 1, 0, 25, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].din, tbl[i].vld, tbl[i].rdy, tbl[i].clr);
      check($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_vld, tbl[i].e_cnt, tbl[i].e_ovf);
    end

    // Reset mid-group: partial 10+20 is lost, next group of 8s averages to 8.
    step(10, 1, 1, 0); check("rg_s0", 0, 0, 0, 0);
    step(20, 1, 1, 0); check("rg_s1", 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    check("rg_inrst", 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    for (int s = 0; s < 4; s++) begin
      step(8, 1, 1, 0);
      if (s == 3) check("rg_res", 8, 1, 1, 0);
      else        check($sformatf("rg_g%0d", s), 0, 0, 0, 0);
    end
    step(0, 0, 1, 0); check("rg_drain", 0, 0, 0, 0);

    // Backpressure: nine groups of value g, ninth is dropped.
    for (int g = 1; g <= 9; g++) begin
      for (int s = 0; s < 4; s++) begin
        step(g, 1, 0, 0);
        c = (s == 3) ? g : g - 1;
        if (c > 8) c = 8;
        check($sformatf("bp_g%0d_s%0d", g, s), (c != 0) ? 1 : 0, c != 0, c,
              (g == 9) && (s == 3));
      end
    end

    // Clear coinciding with another dropping dump: flag stays set.
    for (int s = 0; s < 4; s++) begin
      step(10, 1, 0, s == 3);
      check($sformatf("clrdrop_s%0d", s), 1, 1, 8, 1);
    end
    step(0, 0, 0, 1); check("clr_pulse", 1, 1, 8, 0);

    // Full FIFO with pop on the dump edge: 1 leaves, 11 enters at the tail.
    for (int s = 0; s < 4; s++) begin
      step(11, 1, s == 3, 0);
      if (s == 3) check("pp_dump", 2, 1, 8, 0);
      else        check($sformatf("pp_s%0d", s), 1, 1, 8, 0);
    end

    // Drain: 2..8 then 11; result 9 never appears.
    q = '{2, 3, 4, 5, 6, 7, 8, 11};
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0);
      check($sformatf("drain%0d", k), (k < 7) ? q[k+1] : 0, k < 7, 7 - k, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage placed directly downstream of the 5-tap FIR. It takes the FIR's 10-bit result stream and decimates it by DECIM using accumulate-and-dump (boxcar) averaging. Each result is scaled by a right shift, saturated to OUT_W bits and buffered in a small FIFO. A valid/ready interface lets a slower consumer drain it, and a sticky flag reports dropped results.

## Interface
- IN_W, 10, width of din (matches FIR dataout)
- OUT_W, 8, width of dout
- DECIM, 4, input samples per output (≥2)
- SHIFT, 2, right shift applied to the boxcar sum
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- din  in  IN_W  FIR output sample (unsigned)
- din_valid  in  1  din is a new sample this cycle (tie high behind the FIR)
- dout  out  OUT_W  head-of-FIFO result
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts dout this cycle
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf  out  1  sticky: a result was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of ovf

## Operation
- Phase counter `ph` runs 0..DECIM-1 and advances only when din_valid=1. It wraps to 0 after DECIM-1.
- The accumulator ACC_W = IN_W+$clog2(DECIM) bits never overflows.
  - On a valid sample at ph=0: acc ← din.
  - On a valid sample at any other phase: acc ← acc+din.
- Dump occurs on a valid sample at ph=DECIM-1.
  - sum = acc+din (combinational).
  - res = sum>>SHIFT.
  - If res > 2^OUT_W−1, the result is 2^OUT_W−1; otherwise it is res[OUT_W-1:0].
  - The result is pushed to the FIFO on that same edge.
- FIFO is first-word-fall-through.
  - dout = mem[rd_ptr] when count≠0; dout = 0 when empty.
  - pop = dout_valid & dout_ready.
  - push is allowed when count<DEPTH, or when pop occurs in the same cycle.
- Full with no pop at dump: the result is discarded, ovf ← 1, and FIFO contents are unchanged.
- The ovf set event has priority over clr_ovf in the same cycle.
- din_valid=0 holds ph and acc unchanged; gaps of any length are legal.

## Timing
- Reset values: ph=0, acc=0, FIFO pointers=0, count=0, dout_valid=0, dout=0, ovf=0.
- Reset mid-group discards the partial sum. The next valid sample starts a new group at ph=0.
- Latency: the last sample of a group is accepted at edge k. With the FIFO empty, dout_valid=1 and dout=result are visible immediately after edge k.
- Throughput: one result per DECIM valid samples. There is no stall toward the FIR (no upstream ready).
- Push and pop in the same cycle when count=DEPTH: both occur and count stays DEPTH.
- Push and pop in the same cycle when count=0: not possible, since pop requires dout_valid=1.
- Pointers wrap modulo DEPTH. count is the pointer difference with an extra MSB.

## Structure
- fir_pkg holds:
  - the shared sample-width constants (FIR_OUT_W=10);
  - the default DECIM/SHIFT/DEPTH values;
  - a helper function for ACC_W.
- One sub-module: sync_fifo, parameterised width/depth, FWFT, with count output. Decimation, scaling and saturation stay in fir_decim_out.

## Test plan
- Averaging: din=100 constant, din_valid=1, 8 cycles, dout_ready=1.
  - Required: two results of 100, each appearing right after the 4th and 8th accepted sample.
- Saturation: din=1023 constant.
  - sum=4092, >>2 = 1023.
  - Required: dout=255. ovf stays 0.
- Gaps and reset:
  - Samples 10, 20, then din_valid=0 for 5 cycles, then 30, 40 → dout=25.
  - Repeat, but assert rst after 20. After release, feed 4×8 → dout=8; the earlier partial sum is lost.
- Backpressure/overflow: dout_ready=0, 9 groups with distinct values 1..9.
  - Required: count=8 and ovf=1 after the 9th group.
  - Draining yields 1..8 in order, and the 9th result is absent.
  - Pulsing clr_ovf then clears ovf.
- Full with simultaneous push+pop: FIFO full, dout_ready=1 on the dump edge.
  - Required: count stays 8 and ovf stays 0. The new value exits last.
- clr_ovf asserted on the same edge as a dropping dump → ovf remains 1.
